// File: rtl/dsm_pkg.sv
// Shared types and helpers for the delta-sigma CIC decimator.
package dsm_pkg;

  typedef logic signed [15:0] pcm_t;

  localparam pcm_t PCM_MAX = 16'sh7FFF;
  localparam pcm_t PCM_MIN = 16'sh8000;

  // Integrator/comb width; the extra two bits cover the sign and the +R^N peak.
  function automatic int acc_w(input int order, input int decim);
    return order * $clog2(decim) + 2;
  endfunction

endpackage

// File: rtl/dsm_cic_comb.sv
// One registered CIC comb stage: out = in - previous strobed in.
module dsm_cic_comb
  import dsm_pkg::*;
#(
  parameter int W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] in,
  input  logic                in_stb,
  output logic signed [W-1:0] out,
  output logic                out_stb
);

  logic signed [W-1:0] prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev    <= '0;
      out     <= '0;
      out_stb <= 1'b0;
    end else begin
      out_stb <= in_stb;
      if (in_stb) begin
        out  <= in - prev;
        prev <= in;
      end
    end
  end

endmodule

// File: rtl/dsm_cic_decimator.sv
// 1-bit delta-sigma to signed PCM: sinc^ORDER CIC decimator with saturating rescale.
// Define DSM_DEC_ROUND_EN to round half up before the rescale shift (default truncates).
module dsm_cic_decimator
  import dsm_pkg::*;
#(
  parameter int ORDER     = 3,
  parameter int DECIM     = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        dsm_in,
  output logic signed [OUT_WIDTH-1:0] pcm_out,
  output logic                        pcm_valid,
  input  logic                        pcm_ready,
  output logic                        pcm_ovr
);

  localparam int ACC_W  = acc_w(ORDER, DECIM);
  localparam int CNT_W  = $clog2(DECIM);
  localparam int SHIFT  = ORDER * CNT_W - (OUT_WIDTH - 1);
  localparam int RSH    = (SHIFT > 0) ? SHIFT : 0;
  localparam int LSH    = (SHIFT < 0) ? -SHIFT : 0;
  localparam int RND_SH = (RSH > 0) ? RSH - 1 : 0;
  localparam int EXT_W  = ACC_W + OUT_WIDTH;

  localparam logic signed [ACC_W-1:0] STEP_UP = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] STEP_DN = '1;
  localparam logic signed [EXT_W-1:0] MAX_EXT = EXT_W'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] MIN_EXT = EXT_W'(-(2 ** (OUT_WIDTH - 1)));
`ifdef DSM_DEC_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND = (RSH > 0) ? (EXT_W'(1) << RND_SH) : EXT_W'(0);
`else
  localparam logic signed [EXT_W-1:0] RND = EXT_W'(0);
`endif

  logic signed [ACC_W-1:0] integ     [ORDER];
  logic signed [ACC_W-1:0] integ_nxt [ORDER];
  logic        [CNT_W-1:0] dec_cnt;
  logic                    dec_stb;
  logic signed [ACC_W-1:0] dec_val;
  logic signed [ACC_W-1:0] c_data [ORDER+1];
  logic                    c_stb  [ORDER+1];
  logic signed [EXT_W-1:0] scaled;
  logic signed [OUT_WIDTH-1:0] clamped;
  logic [1:0]              warm_cnt;
  logic                    warm_done;
  logic                    new_sample;

  // All integrators update in parallel from the previous-cycle values; wrap is intentional.
  always_comb begin
    integ_nxt[0] = integ[0] + (dsm_in ? STEP_UP : STEP_DN);
    for (int k = 1; k < ORDER; k++) begin
      integ_nxt[k] = integ[k] + integ[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      integ <= '{default: '0};
    end else if (clk_en) begin
      integ <= integ_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_cnt <= '0;
      dec_stb <= 1'b0;
      dec_val <= '0;
    end else begin
      dec_stb <= clk_en && (dec_cnt == CNT_W'(DECIM - 1));
      if (clk_en) begin
        dec_cnt <= dec_cnt + CNT_W'(1);
        if (dec_cnt == CNT_W'(DECIM - 1)) begin
          dec_val <= integ_nxt[ORDER-1];
        end
      end
    end
  end

  assign c_data[0] = dec_val;
  assign c_stb[0]  = dec_stb;

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    dsm_cic_comb #(.W(ACC_W)) u_comb (
      .clk     (clk),
      .rst     (rst),
      .in      (c_data[k]),
      .in_stb  (c_stb[k]),
      .out     (c_data[k+1]),
      .out_stb (c_stb[k+1])
    );
  end

  always_comb begin
    scaled  = ((EXT_W'(c_data[ORDER]) + RND) >>> RSH) <<< LSH;
    clamped = scaled[OUT_WIDTH-1:0];
    if (scaled > MAX_EXT) begin
      clamped = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (scaled < MIN_EXT) begin
      clamped = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
  end

  // The first ORDER comb results still contain reset history and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt  <= 2'd0;
      warm_done <= 1'b0;
    end else if (c_stb[ORDER] && !warm_done) begin
      if (warm_cnt == 2'(ORDER - 1)) begin
        warm_done <= 1'b1;
      end else begin
        warm_cnt <= warm_cnt + 2'd1;
      end
    end
  end

  assign new_sample = c_stb[ORDER] && warm_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      pcm_ovr   <= 1'b0;
    end else begin
      pcm_ovr <= 1'b0;
      if (new_sample) begin
        pcm_out   <= clamped;
        pcm_valid <= 1'b1;
        pcm_ovr   <= pcm_valid && !pcm_ready;
      end else if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Self-checking bench for dsm_cic_decimator: constant-density vectors, DSM loopback,
// overrun handshake, strobed clk_en timing and asynchronous reset with warm-up repeat.
module tb_dsm_cic_decimator;
  import dsm_pkg::*;

  localparam int ORDER     = 3;
  localparam int DECIM     = 64;
  localparam int OUT_WIDTH = 16;
  localparam int SHIFT     = ORDER * $clog2(DECIM) - (OUT_WIDTH - 1);
  localparam int HLEN      = ORDER * (DECIM - 1) + 1;
  localparam int NS        = 3;

  typedef struct {
    logic [3:0] pat;
    int         plen;
    int         gap;
    int         exp;
  } vec_t;

  typedef struct {
    int exp;
    int tol;
    int n;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;
  logic dsm_in = 1'b0;
  logic pcm_ready = 1'b0;
  logic signed [OUT_WIDTH-1:0] pcm_out;
  logic pcm_valid;
  logic pcm_ovr;

  sb_item_t sb_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wrap_cyc = 0;
  int prev_rise = 0;
  int ovr_cnt = 0;
  int seen = 0;
  int bit_n = 0;
  int hist[0:2047];
  int h[0:HLEN-1];
  bit push_model = 1'b0;
  int push_exp = 0;
  int push_tol = 0;
  bit lat_en = 1'b0;
  int exp_period = 0;
  logic prev_valid = 1'b0;
  vec_t vecs[7];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dsm_cic_decimator #(.ORDER(ORDER), .DECIM(DECIM), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .dsm_in    (dsm_in),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .pcm_ovr   (pcm_ovr)
  );

  task automatic check_output(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    total++;
    if (d > tol || d < -tol) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (tol %0d) at t=%0t", name, act, exp, tol, $time);
    end
  endtask

  // Direct-form sinc^ORDER taps, built by repeated boxcar convolution.
  task automatic build_taps();
    int tmp[0:HLEN-1];
    foreach (h[i]) h[i] = (i < DECIM) ? 1 : 0;
    for (int s = 1; s < ORDER; s++) begin
      for (int i = 0; i < HLEN; i++) begin
        tmp[i] = 0;
        for (int j = 0; j < DECIM; j++) begin
          if (i - j >= 0) tmp[i] += h[i-j];
        end
      end
      h = tmp;
    end
  endtask

  // Expected PCM after input bit n; the integrator chain delays the input by ORDER-1 bits.
  function automatic int ref_sample(input int n);
    longint y;
    int k;
    int s;
    y = 0;
    for (int t = 0; t < HLEN; t++) begin
      k = n - (ORDER - 1) - t;
      if (k >= 1) y += longint'(h[t] * hist[k]);
    end
`ifdef DSM_DEC_ROUND_EN
    y += longint'(1 << (SHIFT - 1));
`endif
    s = int'(y >>> SHIFT);
    if (s > int'(PCM_MAX)) s = int'(PCM_MAX);
    if (s < int'(PCM_MIN)) s = int'(PCM_MIN);
    return s;
  endfunction

  task automatic apply_stimulus(input logic b, input int gap);
    sb_item_t it;
    clk_en = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    clk_en = 1'b1;
    dsm_in = b;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    bit_n++;
    hist[bit_n] = b ? 1 : -1;
    if (bit_n % DECIM == 0) begin
      wrap_cyc = cyc;
      if (bit_n / DECIM > ORDER) begin
        it.n   = bit_n;
        it.exp = push_model ? ref_sample(bit_n) : push_exp;
        it.tol = push_model ? 0 : push_tol;
        sb_q.push_back(it);
      end
    end
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    clk_en = 1'b0;
    sb_q.delete();
    foreach (hist[i]) hist[i] = 0;
    bit_n     = 0;
    prev_rise = 0;
    ovr_cnt   = 0;
    seen      = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_vector(input vec_t v);
    do_reset();
    pcm_ready  = 1'b1;
    push_model = 1'b0;
    push_exp   = v.exp;
    push_tol   = 0;
    lat_en     = 1'b1;
    exp_period = (v.gap + 1) * DECIM;
    for (int i = 0; i < (ORDER + NS) * DECIM; i++) begin
      apply_stimulus(v.pat[v.plen - 1 - (i % v.plen)], v.gap);
    end
    repeat (12) @(posedge clk);
    #1;
    check_output("drained", sb_q.size(), 0, 0);
    check_output("sample_count", seen, NS, 0);
    lat_en = 1'b0;
  endtask

  // Output monitor: latency/period on each rising pcm_valid, scoreboard pop on accept.
  always @(negedge clk) begin
    sb_item_t it;
    if (rst) begin
      if (pcm_valid && !prev_valid && lat_en) begin
        check_output("latency", cyc - wrap_cyc, ORDER + 1, 0);
        if (prev_rise != 0) check_output("period", cyc - prev_rise, exp_period, 0);
        prev_rise = cyc;
      end
      if (pcm_ovr) begin
        ovr_cnt++;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
      if (pcm_valid && pcm_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_sample: got pcm_out=%0d, want no sample at t=%0t", pcm_out, $time);
        end else begin
          it = sb_q.pop_front();
          check_output("sample", int'(pcm_out), it.exp, it.tol);
          seen++;
        end
      end
    end
    prev_valid = pcm_valid;
  end

  initial begin
    int acc;
    logic b;

    vecs[0] = '{4'b1111, 4, 0, 32767};
    vecs[1] = '{4'b0000, 4, 0, -32768};
    vecs[2] = '{4'b0010, 2, 0, 0};
    vecs[3] = '{4'b1110, 4, 0, 16384};
    vecs[4] = '{4'b1000, 4, 0, -16384};
    vecs[5] = '{4'b1100, 4, 0, 0};
    vecs[6] = '{4'b1110, 4, 3, 16384};

    #1 rst = 1'b0;
    build_taps();
    #3;
    check_output("reset_pcm_out", int'(pcm_out), 0, 0);
    check_output("reset_pcm_valid", int'(pcm_valid), 0, 0);
    check_output("reset_pcm_ovr", int'(pcm_ovr), 0, 0);

    for (int v = 0; v < 7; v++) begin
      $display("[TB] vector %0d: pattern=%b len=%0d gap=%0d", v, vecs[v].pat, vecs[v].plen, vecs[v].gap);
      run_vector(vecs[v]);
    end

    // Loopback from a first-order DSM modulator fed with a constant 0x2000.
    $display("[TB] loopback 16'sh2000");
    do_reset();
    pcm_ready  = 1'b1;
    push_model = 1'b0;
    push_exp   = 8192;
    push_tol   = 64;
    acc = 0;
    for (int i = 0; i < (ORDER + NS) * DECIM; i++) begin
      b = (acc >= 0);
      apply_stimulus(b, 0);
      acc += 8192 - (b ? 32768 : -32768);
    end
    repeat (12) @(posedge clk);
    #1;
    check_output("loop_drained", sb_q.size(), 0, 0);
    check_output("loop_count", seen, NS, 0);

    // Overrun: two samples arrive while the consumer stalls.
    $display("[TB] overrun sequence");
    do_reset();
    pcm_ready  = 1'b0;
    push_model = 1'b1;
    for (int i = 0; i < 4 * DECIM; i++) apply_stimulus(1'b1, 0);
    for (int i = 0; i < DECIM; i++) apply_stimulus(1'b0, 0);
    repeat (8) @(posedge clk);
    #1;
    check_output("ovr_pulses", ovr_cnt, 1, 0);
    check_output("ovr_valid", int'(pcm_valid), 1, 0);
    check_output("ovr_latest", int'(pcm_out), ref_sample(5 * DECIM), 0);
    check_output("ovr_queue", sb_q.size(), 1, 0);
    pcm_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("valid_drop", int'(pcm_valid), 0, 0);
    check_output("ovr_accepted", seen, 1, 0);

    pcm_ready = 1'b0;
    for (int i = 0; i < DECIM; i++) apply_stimulus(1'b0, 0);
    repeat (8) @(posedge clk);
    #1;
    check_output("held_valid", int'(pcm_valid), 1, 0);
    check_output("ovr_no_extra", ovr_cnt, 1, 0);

    // Asynchronous reset away from any clock edge, then warm-up must repeat.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_output("async_pcm_out", int'(pcm_out), 0, 0);
    check_output("async_pcm_valid", int'(pcm_valid), 0, 0);
    check_output("async_pcm_ovr", int'(pcm_ovr), 0, 0);
    run_vector(vecs[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
